// File: rtl/dffram_port_arbiter.sv
// DFFRAM port arbiter: shares one single-port DFFRAM between a CPU port and a
// read-only housekeeping (HK) port. The CPU normally wins. A pending HK request
// is granted once the CPU goes idle, or after it has lost STARVE_MAX times in a row.
module dffram_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    // CPU port
    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    // Housekeeping port
    input  logic        hk_req,
    input  logic [7:0]  hk_addr,
    output logic        hk_ack,
    output logic [31:0] hk_rdata,
    // DFFRAM port
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [7:0]  ram_a,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do
);

    localparam int WCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] WC_MAX = WCW'(STARVE_MAX);

    typedef enum logic [1:0] {
        HK_IDLE = 2'd0,
        HK_PEND = 2'd1,
        HK_RD   = 2'd2,
        HK_ACK  = 2'd3
    } hk_state_t;

    hk_state_t       r_state;
    hk_state_t       w_state_nxt;
    logic [WCW-1:0]  r_wait_cnt;
    logic [WCW-1:0]  w_wait_nxt;
    logic [7:0]      r_hk_addr;
    logic [7:0]      w_hk_addr_nxt;
    logic            r_hk_ack;
    logic            w_hk_ack_nxt;
    logic [31:0]     r_hk_rdata;
    logic [31:0]     w_hk_rdata_nxt;
    logic            r_cpu_rvalid;
    logic            w_hk_gnt;
    logic            w_cpu_gnt;

    // Port ownership: HK wins in PEND when the CPU is idle or has starved HK long
    // enough; otherwise the CPU gets the port whenever it asks. Nothing is granted
    // while reset is held, so the RAM stays disabled.
    always_comb begin
        w_hk_gnt  = 1'b0;
        w_cpu_gnt = 1'b0;
        if (!core_rstn) begin
            w_hk_gnt  = 1'b0;
            w_cpu_gnt = 1'b0;
        end else if ((r_state == HK_PEND) && (!cpu_req || (r_wait_cnt == WC_MAX))) begin
            w_hk_gnt  = 1'b1;
            w_cpu_gnt = 1'b0;
        end else begin
            w_hk_gnt  = 1'b0;
            w_cpu_gnt = cpu_req;
        end
    end

    // HK FSM next-state: latch the address on request, count CPU wins while
    // pending (saturating), capture RAM data one cycle after the grant.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_nxt     = r_wait_cnt;
        w_hk_addr_nxt  = r_hk_addr;
        w_hk_ack_nxt   = 1'b0;
        w_hk_rdata_nxt = r_hk_rdata;
        case (r_state)
            HK_IDLE: begin
                w_wait_nxt = {WCW{1'b0}};
                if (hk_req) begin
                    w_hk_addr_nxt = hk_addr;
                    w_state_nxt   = HK_PEND;
                end else begin
                    w_state_nxt   = HK_IDLE;
                end
            end
            HK_PEND: begin
                if (w_hk_gnt) begin
                    w_state_nxt = HK_RD;
                end else if (r_wait_cnt != WC_MAX) begin
                    w_wait_nxt  = r_wait_cnt + WCW'(1);
                end else begin
                    w_wait_nxt  = r_wait_cnt;
                end
            end
            HK_RD: begin
                w_hk_rdata_nxt = ram_do;
                w_hk_ack_nxt   = 1'b1;
                w_state_nxt    = HK_ACK;
            end
            HK_ACK: begin
                w_state_nxt = HK_IDLE;
            end
            default: begin
                w_state_nxt = HK_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_state      <= HK_IDLE;
            r_wait_cnt   <= {WCW{1'b0}};
            r_hk_addr    <= 8'h00;
            r_hk_ack     <= 1'b0;
            r_hk_rdata   <= 32'h0000_0000;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_hk_addr    <= w_hk_addr_nxt;
            r_hk_ack     <= w_hk_ack_nxt;
            r_hk_rdata   <= w_hk_rdata_nxt;
            r_cpu_rvalid <= w_cpu_gnt && (cpu_we == 4'h0);
        end
    end

    // RAM port mux: CPU address/data by default, latched HK address on HK grant.
    assign ram_en     = w_cpu_gnt | w_hk_gnt;
    assign ram_we     = w_cpu_gnt ? cpu_we : 4'h0;
    assign ram_a      = w_hk_gnt ? r_hk_addr : cpu_addr;
    assign ram_di     = cpu_wdata;

    assign cpu_gnt    = w_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = ram_do;
    assign hk_ack     = r_hk_ack;
    assign hk_rdata   = r_hk_rdata;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Directed + constrained-random bench for dffram_port_arbiter with a
// behavioural DFFRAM and a reference memory.
module tb_dffram_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        core_clk = 1'b0;
    logic        core_rstn;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        hk_req;
    logic [7:0]  hk_addr;
    logic        hk_ack;
    logic [31:0] hk_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = 32'h0;

    logic [31:0] mem     [0:255] = '{default: 32'h0};
    logic [31:0] ref_mem [0:255] = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    dffram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .core_clk  (core_clk),
        .core_rstn (core_rstn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .hk_req    (hk_req),
        .hk_addr   (hk_addr),
        .hk_ack    (hk_ack),
        .hk_rdata  (hk_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    always #5 core_clk = ~core_clk;

    // Behavioural DFFRAM: byte writes, registered read data.
    always @(posedge core_clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            end
            ram_do <= mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge core_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge core_clk);
    endtask

    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_ack;
    logic [31:0] hk_exp;
    logic [7:0]  hk_lat;
    logic        hk_granted;
    logic        hk_ack_seen;
    logic        last_cpu_gnt;
    logic        hkg;
    int          hk_cd;
    int          hk_wait;

    initial begin
        core_rstn = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 4'hF;
        cpu_addr  = 8'h10;
        cpu_wdata = 32'h0;
        hk_req    = 1'b0;
        hk_addr   = 8'h00;

        // Reset state, CPU request held during reset must not reach the RAM
        repeat (2) @(posedge core_clk);
        smp();
        chk1("rst_hk_ack", hk_ack, 1'b0);
        chk("rst_hk_rdata", hk_rdata, 32'h0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);

        // First edge after release grants: full write DEADBEEF @10
        nxt();
        core_rstn = 1'b1;
        cpu_wdata = 32'hDEAD_BEEF;
        smp();
        chk1("wr0_gnt", cpu_gnt, 1'b1);
        chk1("wr0_ram_en", ram_en, 1'b1);
        chk("wr0_ram_we", 32'(ram_we), 32'hF);
        chk("wr0_ram_a", 32'(ram_a), 32'h10);
        chk("wr0_ram_di", ram_di, 32'hDEAD_BEEF);

        // Partial write 11223344 @11 with we=0101 -> 00220044
        nxt();
        cpu_addr = 8'h11; cpu_we = 4'b0101; cpu_wdata = 32'h1122_3344;
        smp();
        chk1("wr1_gnt", cpu_gnt, 1'b1);
        chk("wr1_ram_we", 32'(ram_we), 32'h5);
        chk1("wr_no_rvalid", cpu_rvalid, 1'b0);

        // Back-to-back reads @10, @11
        nxt();
        cpu_addr = 8'h10; cpu_we = 4'h0;
        smp();
        chk1("rd0_gnt", cpu_gnt, 1'b1);
        chk1("wr1_no_rvalid", cpu_rvalid, 1'b0);
        nxt();
        cpu_addr = 8'h11;
        smp();
        chk1("rd0_rvalid", cpu_rvalid, 1'b1);
        chk("rd0_rdata", cpu_rdata, 32'hDEAD_BEEF);
        nxt();
        cpu_req = 1'b0; cpu_addr = 8'h33; cpu_wdata = 32'h5555_AAAA; cpu_we = 4'hF;
        smp();
        chk1("rd1_rvalid", cpu_rvalid, 1'b1);
        chk("rd1_rdata", cpu_rdata, 32'h0022_0044);
        chk1("idle_ram_en", ram_en, 1'b0);
        chk("idle_ram_we", 32'(ram_we), 32'h0);
        chk("idle_ram_a", 32'(ram_a), 32'h33);
        chk("idle_ram_di", ram_di, 32'h5555_AAAA);
        nxt();
        cpu_we = 4'h0;
        smp();
        chk1("idle_rvalid", cpu_rvalid, 1'b0);

        // HK read with CPU idle: grant 1 cycle after req, ack 2 after grant
        nxt();
        hk_req = 1'b1; hk_addr = 8'h10;
        smp();
        chk1("hk0_req_cycle_en", ram_en, 1'b0);
        nxt();
        smp();
        chk1("hk0_gnt_en", ram_en, 1'b1);
        chk("hk0_gnt_a", 32'(ram_a), 32'h10);
        chk("hk0_gnt_we", 32'(ram_we), 32'h0);
        chk1("hk0_cpu_gnt", cpu_gnt, 1'b0);
        nxt();
        smp();
        chk1("hk0_rd_ack", hk_ack, 1'b0);
        chk1("hk0_rd_en", ram_en, 1'b0);
        nxt();
        hk_req = 1'b0;
        smp();
        chk1("hk0_ack", hk_ack, 1'b1);
        chk("hk0_rdata", hk_rdata, 32'hDEAD_BEEF);
        nxt();
        smp();
        chk1("hk0_ack_pulse", hk_ack, 1'b0);
        chk("hk0_rdata_held", hk_rdata, 32'hDEAD_BEEF);

        // CPU read granted, reset before the next edge: no rvalid
        nxt();
        cpu_req = 1'b1; cpu_addr = 8'h10; cpu_we = 4'h0;
        smp();
        chk1("rstcpu_gnt", cpu_gnt, 1'b1);
        core_rstn = 1'b0; cpu_req = 1'b0;
        nxt();
        core_rstn = 1'b1;
        smp();
        chk1("rstcpu_no_rvalid", cpu_rvalid, 1'b0);

        // Reset pulsed while HK is in HK_RD
        nxt();
        hk_req = 1'b1; hk_addr = 8'h10;
        nxt();
        smp();
        chk1("hkrst_gnt", ram_en, 1'b1);
        nxt();
        hk_req = 1'b0; core_rstn = 1'b0;
        smp();
        chk1("hkrst_ack", hk_ack, 1'b0);
        chk("hkrst_rdata", hk_rdata, 32'h0);
        nxt();
        core_rstn = 1'b1;
        smp();
        chk1("hkrst_no_ack", hk_ack, 1'b0);
        chk1("hkrst_no_en", ram_en, 1'b0);
        nxt();
        hk_req = 1'b1; hk_addr = 8'h11;
        smp();
        chk1("hkrst_idle_en", ram_en, 1'b0);
        nxt();
        smp();
        chk1("hkrst_regrant_en", ram_en, 1'b1);
        chk("hkrst_regrant_a", 32'(ram_a), 32'h11);
        nxt();
        nxt();
        hk_req = 1'b0;
        smp();
        chk1("hkrst_ack2", hk_ack, 1'b1);
        chk("hkrst_rdata2", hk_rdata, 32'h0022_0044);

        // Starvation: CPU reads @11 continuously, HK @10 with addr changed in PEND
        nxt();
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 8'h11;
        hk_req = 1'b1; hk_addr = 8'h10;
        smp();
        chk1("stv_s0_gnt", cpu_gnt, 1'b1);
        for (int i = 1; i <= STARVE_MAX; i++) begin
            nxt();
            if (i == 1) hk_addr = 8'h20;
            smp();
            chk1("stv_cpu_gnt", cpu_gnt, 1'b1);
        end
        nxt();
        smp();
        chk1("stv_stall_gnt", cpu_gnt, 1'b0);
        chk1("stv_hk_en", ram_en, 1'b1);
        chk("stv_hk_a", 32'(ram_a), 32'h10);
        chk("stv_hk_we", 32'(ram_we), 32'h0);
        chk1("stv_rvalid_s5", cpu_rvalid, 1'b1);
        chk("stv_rdata_s5", cpu_rdata, 32'h0022_0044);
        nxt();
        smp();
        chk1("stv_rd_cpu_gnt", cpu_gnt, 1'b1);
        chk1("stv_rd_ack", hk_ack, 1'b0);
        chk1("stv_rd_rvalid", cpu_rvalid, 1'b0);
        nxt();
        hk_req = 1'b0;
        smp();
        chk1("stv_ack", hk_ack, 1'b1);
        chk("stv_hk_rdata", hk_rdata, 32'hDEAD_BEEF);
        chk1("stv_ack_cpu_gnt", cpu_gnt, 1'b1);
        chk1("stv_ack_rvalid", cpu_rvalid, 1'b1);
        chk("stv_ack_rdata", cpu_rdata, 32'h0022_0044);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk1("stv_ack_pulse", hk_ack, 1'b0);

        // Random mixed traffic on addresses 0..7 against the reference memory
        exp_rv = 1'b0; exp_rd = 32'h0; hk_cd = 0; hk_exp = 32'h0; hk_lat = 8'h00;
        hk_granted = 1'b0; hk_ack_seen = 1'b0; last_cpu_gnt = 1'b0; hk_wait = 0;
        for (int c = 0; c < 400; c++) begin
            nxt();
            if (!(cpu_req && !last_cpu_gnt)) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                cpu_addr  = 8'($urandom_range(0, 7));
                cpu_wdata = $urandom;
            end
            if (hk_req) begin
                if (hk_ack_seen) hk_req = 1'b0;
                else hk_addr = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 99) < 25) begin
                hk_req = 1'b1; hk_addr = 8'($urandom_range(0, 7));
                hk_lat = hk_addr; hk_granted = 1'b0; hk_wait = 0;
            end
            smp();
            chk1("rnd_rvalid", cpu_rvalid, exp_rv);
            if (exp_rv) chk("rnd_rdata", cpu_rdata, exp_rd);
            exp_ack = 1'b0;
            if (hk_cd != 0) begin
                hk_cd--;
                exp_ack = (hk_cd == 0);
            end
            chk1("rnd_hk_ack", hk_ack, exp_ack);
            if (exp_ack) chk("rnd_hk_rdata", hk_rdata, hk_exp);
            hk_ack_seen = hk_ack;
            hkg = ram_en && !cpu_gnt;
            if (cpu_gnt) begin
                chk1("rnd_gnt_has_req", cpu_req, 1'b1);
                chk("rnd_cpu_ram_a", 32'(ram_a), 32'(cpu_addr));
                chk("rnd_cpu_ram_we", 32'(ram_we), 32'(cpu_we));
            end else if (cpu_req) begin
                chk1("rnd_stall_owner", ram_en, 1'b1);
            end
            if (hkg) begin
                chk("rnd_hk_ram_we", 32'(ram_we), 32'h0);
                chk("rnd_hk_ram_a", 32'(ram_a), 32'(hk_lat));
                chk1("rnd_hk_gnt_pending", hk_req && !hk_granted, 1'b1);
                chk1("rnd_hk_wait_bound", hk_wait <= STARVE_MAX + 1, 1'b1);
                hk_granted = 1'b1;
                hk_cd = 2;
                hk_exp = ref_mem[hk_lat];
            end else if (hk_req && !hk_granted) begin
                chk1("rnd_hk_wait_bound", hk_wait <= STARVE_MAX + 1, 1'b1);
                hk_wait++;
            end
            exp_rv = cpu_gnt && (cpu_we == 4'h0);
            if (exp_rv) exp_rd = ref_mem[cpu_addr];
            if (cpu_gnt && (cpu_we != 4'h0)) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu_we[b]) ref_mem[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
                end
            end
            last_cpu_gnt = cpu_gnt;
        end

        nxt();
        cpu_req = 1'b0; hk_req = 1'b0;
        repeat (4) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
